// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR        = 10;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned IDX_W     = 4;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_SERVE
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse (as x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  // Addition chain to x^254; zero maps to zero as AES requires.
  always_comb begin
    x2   = gf_mul(din, din);
    x3   = gf_mul(x2, din);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    dout = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

// File: rtl/inv_mixColumns.sv
// AES InvMixColumns over a 128-bit state, byte 0 in [127:120], column-major.
module inv_mixColumns
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] dout
);

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    dout = '0;
    a0   = 8'h00;
    a1   = 8'h00;
    a2   = 8'h00;
    a3   = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0 = din[(127 - 32*c) -: 8];
      a1 = din[(119 - 32*c) -: 8];
      a2 = din[(111 - 32*c) -: 8];
      a3 = din[(103 - 32*c) -: 8];
      dout[(127 - 32*c) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      dout[(119 - 32*c) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      dout[(111 - 32*c) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      dout[(103 - 32*c) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  end

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption round-key generator: expands a key once into an 11-entry store,
// then replays round keys 10..0 over a valid/ready stream until a new key is loaded.
module aes_dec_key_sched
  import aes_pkg::*;
#(
  parameter bit EQ_INV = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [KEY_W-1:0]   rk_q [0:NR];
  logic               ld_key;
  logic               wr_exp;

  logic [KEY_W-1:0]   prev_key, next_key, raw_key;
  word_t              w0, w1, w2, w3, rot_w, sub_w, t;

  // One expansion step from the previously written round key.
  assign prev_key = rk_q[cnt_q - 4'd1];
  assign {w0, w1, w2, w3} = prev_key;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot_w[8*g +: 8]),
      .dout (sub_w[8*g +: 8])
    );
  end

  assign t        = sub_w ^ {rcon_q, 24'h000000};
  assign next_key = {w0 ^ t, w0 ^ w1 ^ t, w0 ^ w1 ^ w2 ^ t, w0 ^ w1 ^ w2 ^ w3 ^ t};

  // Next-state logic; a key load in SERVE wins over the index update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    ld_key  = 1'b0;
    wr_exp  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          ld_key  = 1'b1;
          rcon_d  = RCON_INIT;
          cnt_d   = 4'd1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        wr_exp = 1'b1;
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          state_d = ST_SERVE;
          idx_d   = 4'(NR);
        end
      end
      ST_SERVE: begin
        if (rk_ready) idx_d = (idx_q == 4'd0) ? 4'(NR) : idx_q - 4'd1;
        if (key_valid) begin
          ld_key  = 1'b1;
          rcon_d  = RCON_INIT;
          cnt_d   = 4'd1;
          idx_d   = idx_q;
          state_d = ST_EXPAND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= RCON_INIT;
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      if (ld_key) rk_q[0] <= key_in;
      if (wr_exp) rk_q[cnt_q] <= next_key;
    end
  end

  assign key_ready = (state_q != ST_EXPAND);
  assign rk_valid  = (state_q == ST_SERVE);
  assign busy      = (state_q == ST_EXPAND);
  assign rk_idx    = idx_q;
  assign rk_last   = rk_valid && (idx_q == 4'd0);
  assign raw_key   = rk_q[idx_q];

  // Equivalent inverse cipher: inner round keys pass through InvMixColumns.
  if (EQ_INV) begin : g_eq_inv
    logic [KEY_W-1:0] imc_key;
    inv_mixColumns u_imc (
      .din  (raw_key),
      .dout (imc_key)
    );
    assign rk_out = (idx_q != 4'd0 && idx_q != 4'(NR)) ? imc_key : raw_key;
  end else begin : g_raw
    assign rk_out = raw_key;
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench: raw-key and equivalent-inverse instances run in lockstep on shared stimulus.
module tb_aes_dec_key_sched;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    bit           chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in = '0;

  logic         key_ready0, rk_valid0, rk_last0, busy0;
  logic         key_ready1, rk_valid1, rk_last1, busy1;
  logic [127:0] rk_out0, rk_out1;
  logic [3:0]   rk_idx0, rk_idx1;

  logic [127:0] tab_a [0:10];
  logic [127:0] tab_b [0:10];
  bit           known_a [0:10];
  bit           known_b [0:10];
  logic [127:0] cur_tab [0:10];
  bit           cur_known [0:10];
  int           exp_idx;

  logic [127:0] hold_d [0:1];
  logic [3:0]   hold_i [0:1];
  bit           held [0:1];

  always #5 clk = ~clk;

  aes_dec_key_sched #(.EQ_INV(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready0), .key_in(key_in),
    .rk_valid(rk_valid0), .rk_ready(rk_ready), .rk_out(rk_out0), .rk_idx(rk_idx0),
    .rk_last(rk_last0), .busy(busy0)
  );

  aes_dec_key_sched #(.EQ_INV(1'b1)) u_eqv (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready1), .key_in(key_in),
    .rk_valid(rk_valid1), .rk_ready(rk_ready), .rk_out(rk_out1), .rk_idx(rk_idx1),
    .rk_last(rk_last1), .busy(busy1)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Golden InvMixColumns: row j of the circulant [0e 0b 0d 09] starts at byte j.
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0]   a [0:3];
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int j = 0; j < 4; j++)
        r[127 - 32*c - 8*j -: 8] = gm(a[j], 8'h0e) ^ gm(a[(j+1)%4], 8'h0b)
                                 ^ gm(a[(j+2)%4], 8'h0d) ^ gm(a[(j+3)%4], 8'h09);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_next();
    exp_t e;
    logic [127:0] raw;
    raw   = cur_tab[exp_idx];
    e.idx  = 4'(exp_idx);
    e.chk  = cur_known[exp_idx];
    e.data = raw;
    q0.push_back(e);
    if (exp_idx >= 1 && exp_idx <= 9) e.data = inv_mix(raw);
    q1.push_back(e);
    exp_idx = (exp_idx == 0) ? 10 : exp_idx - 1;
  endtask

  task automatic mon(input int d, input logic v, input logic [3:0] idx, input logic last,
                     input logic [127:0] out);
    exp_t e;
    bool_check: begin
      if (held[d] && v) begin
        chk($sformatf("dut%0d stall data", d), out, hold_d[d]);
        chk($sformatf("dut%0d stall idx", d), 128'(idx), 128'(hold_i[d]));
      end
    end
    held[d]   = (v === 1'b1) && (rk_ready === 1'b0);
    hold_d[d] = out;
    hold_i[d] = idx;
    if (v === 1'b1 && rk_ready === 1'b1) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected transfer: got idx %0d required none", d, idx);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d idx", d), 128'(idx), 128'(e.idx));
        chk($sformatf("dut%0d last idx%0d", d, e.idx), 128'(last), 128'(e.idx == 4'd0));
        if (e.chk) chk($sformatf("dut%0d rk idx%0d", d, e.idx), out, e.data);
      end
    end
  endtask

  // Monitor samples at the falling edge; a transfer is valid&&ready here.
  always @(negedge clk) begin
    mon(0, rk_valid0, rk_idx0, rk_last0, rk_out0);
    mon(1, rk_valid1, rk_idx1, rk_last1, rk_out1);
  end

  task automatic chk_reset(input string name);
    chk({name, " key_ready"}, 128'(key_ready0), 128'(1'b1));
    chk({name, " rk_valid"},  128'(rk_valid0),  128'(1'b0));
    chk({name, " rk_idx"},    128'(rk_idx0),    128'(4'd0));
    chk({name, " rk_last"},   128'(rk_last0),   128'(1'b0));
    chk({name, " busy"},      128'(busy0),      128'(1'b0));
    chk({name, " rk_out"},    rk_out0,          128'h0);
    chk({name, " eq key_ready"}, 128'(key_ready1), 128'(1'b1));
    chk({name, " eq rk_valid"},  128'(rk_valid1),  128'(1'b0));
    chk({name, " eq rk_out"},    rk_out1,          128'h0);
  endtask

  // Called at posedge+1: drive a key for one handshake edge.
  task automatic accept(input logic [127:0] k, input bit keep);
    key_valid = 1'b1;
    key_in    = k;
    @(posedge clk); #1;
    if (!keep) key_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!rk_valid0 && n < 30) begin
        chk({name, " busy"}, 128'(busy0), 128'(1'b1));
        chk({name, " key_ready"}, 128'(key_ready0), 128'(1'b0));
      end
    end while (!rk_valid0 && n < 30);
    chk({name, " latency"}, 128'(n), 128'(10));
  endtask

  task automatic consume(input int n, input bit rnd);
    int left;
    int budget;
    left   = n;
    budget = 0;
    for (int i = 0; i < n; i++) push_next();
    while (left > 0 && budget < 40*n + 50) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready && rk_valid0) left--;
      @(posedge clk); #1;
      budget++;
    end
    rk_ready = 1'b0;
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL consume: got %0d transfers required %0d", n - left, n);
    end
  endtask

  initial begin
    tab_a = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
              128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
              128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
              128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
              128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tab_b = '{default: 128'h0};
    tab_b[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    tab_b[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    tab_b[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    known_a = '{default: 1'b1};
    known_b = '{default: 1'b0};
    known_b[0]  = 1'b1;
    known_b[1]  = 1'b1;
    known_b[10] = 1'b1;
    held = '{default: 1'b0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset("reset");

    // FIPS-197 key, full-rate consumer; one replay plus the wrap to idx 10.
    cur_tab = tab_a; cur_known = known_a; exp_idx = 10;
    accept(tab_a[0], 1'b0);
    wait_valid("fips");
    consume(12, 1'b0);

    // Random backpressure across two replays, then stop before idx 5.
    consume(22, 1'b1);
    consume(4, 1'b0);

    // New key together with the idx-5 transfer.
    rk_ready = 1'b1;
    push_next();
    accept(tab_b[0], 1'b0);
    rk_ready = 1'b0;
    cur_tab = tab_b; cur_known = known_b; exp_idx = 10;
    wait_valid("reload");
    consume(11, 1'b0);

    // key_valid held through expansion with a different key on the bus.
    accept(tab_a[0], 1'b1);
    key_in = tab_b[0];
    cur_tab = tab_a; cur_known = known_a; exp_idx = 10;
    wait_valid("held");
    key_valid = 1'b0;
    consume(11, 1'b1);

    // Reset during expansion at cnt=4.
    accept(tab_b[0], 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset("rst expand");

    // Reset while serving.
    cur_tab = tab_a; cur_known = known_a; exp_idx = 10;
    accept(tab_a[0], 1'b0);
    wait_valid("pre serve rst");
    consume(13, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset("rst serve");

    // Normal operation resumes after reset.
    cur_tab = tab_b; cur_known = known_b; exp_idx = 10;
    accept(tab_b[0], 1'b0);
    wait_valid("post rst");
    consume(11, 1'b1);

    @(posedge clk); #1;
    chk("raw queue empty", 128'(q0.size()), 128'(0));
    chk("eq queue empty", 128'(q1.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_sched.md
# aes_dec_key_sched

Round-key generator for the AES-128 decryption datapath. Accepts a 128-bit cipher key, runs the forward key expansion iteratively at one round key per cycle into an 11-entry key store, then serves round keys in reverse order (round 10 down to round 0) over a valid/ready stream. That stream feeds the AddRoundKey stage that sits directly ahead of inv_mixColumns in each decryption round. Optionally pre-applies InvMixColumns to round keys 1..9 for the equivalent inverse cipher. Keys are retained and replayed for every subsequent block until a new key is loaded.

## Interface
- EQ_INV, default 0: 1 = rk_out for rounds 1..9 is InvMixColumns(rk[i]); rounds 0 and 10 are always raw; 0 = all keys raw.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- key_valid  in  1  key_in valid.
- key_ready  out  1  block can accept a key.
- key_in  in  128  cipher key, byte 0 in [127:120].
- rk_valid  out  1  rk_out holds a valid round key.
- rk_ready  in  1  consumer accepts rk_out.
- rk_out  out  128  round key for round rk_idx, same byte order as key_in.
- rk_idx  out  4  round number of rk_out (10..0).
- rk_last  out  1  rk_valid && rk_idx==0.
- busy  out  1  expansion in progress.

## Operation
- States: IDLE, EXPAND, SERVE. Reset -> IDLE.
- Key handshake: key_valid && key_ready on a rising edge. key_ready = 1 in IDLE and SERVE, 0 in EXPAND.
- IDLE: on handshake, rk[0] <= key_in, rcon <= 8'h01, cnt <= 1, go to EXPAND.
- EXPAND: each cycle, with p = rk[cnt-1] as words w0..w3, t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; rk[cnt] = {w0^t, w0^w1^t, w0^w1^w2^t, w0^w1^w2^w3^t}; rcon <= xtime(rcon) (GF(2^8), poly 0x11B; 0x80 -> 0x1B); cnt++. When cnt==10 is written: go to SERVE, rk_idx <= 10.
- SERVE: rk_valid=1; rk_out = mux of rk[rk_idx], InvMixColumns-transformed when EQ_INV && 1<=rk_idx<=9. On rk handshake: rk_idx-- ; if rk_idx==0, rk_idx <= 10 (replay for next block), stay SERVE.
- Key handshake in SERVE: reload as from IDLE and go to EXPAND. If an rk handshake occurs in the same cycle, it completes (consumer keeps current data) and then the index is discarded.
- rk_valid=0 in IDLE and EXPAND; busy=1 only in EXPAND.
- rk_out is combinational from the key store and rk_idx. It is stable while rk_valid && !rk_ready.
- key_valid is ignored in EXPAND; there is no abort.

## Timing
- Reset values: state IDLE, key_ready 1, rk_valid 0, rk_idx 0, rk_last 0, busy 0, rk_out 0 (key store cleared), rcon 0x01, cnt 0.
- Key accept edge E0; rk[1..10] written on E1..E10; rk_valid high after E10. That is 10 cycles of latency and a throughput of 1 key per 11 cycles of setup.
- SERVE: one round key per cycle while rk_ready=1. A full replay of 11 keys takes 11 cycles.
- rst_n low mid-EXPAND or mid-SERVE: next edge returns all state to reset values, and no partial keys are visible afterwards.
- Output paths are combinational: rk_out (one 11:1 mux plus optional InvMixColumns), key_ready, rk_valid, rk_last. No input-to-output combinational paths.

## Structure
- Shared package aes_pkg holds:
  - NR = 10
  - the state enum
  - the xtime function
  - the rcon reset value 8'h01
- Sub-module aes_sbox: forward S-box, 8-bit combinational, 4 instances for SubWord.
- The existing inv_mixColumns module is instantiated once on the mux output when EQ_INV=1.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, EQ_INV=0, rk_ready=1 -> rk_valid 10 cycles after accept; rk_idx 10 d014f9a8c9ee2589e13f0cc8b6630ca6; idx 9 ac7766f319fadc2128d12941575c006e; idx 1 a0fafe1788542cb123a339392a6c7605; idx 0 equals key with rk_last=1; then idx 10 again.
- Same key, EQ_INV=1 -> idx 10 and idx 0 unchanged; idx 1..9 equal InvMixColumns of the raw keys (golden model).
- Backpressure: rk_ready toggled randomly -> each key is transferred exactly once per replay, and rk_out/rk_idx are held stable while stalled.
- New key 000102030405060708090a0b0c0d0e0f in SERVE at idx 5, with a simultaneous rk handshake -> idx 5 transfer completes, busy for 10 cycles, then idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- key_valid held during EXPAND -> key_ready=0, key ignored, and keys match the first key.
- rst_n low for 1 cycle at EXPAND cnt=4 and again in SERVE -> all outputs return to reset values the next edge, and key_ready=1.
